word_uart_tx: RTL and testbench

Return-path serializer for the UART coprocessor. It accepts one wide result word on a single-cycle valid strobe, latches it, and transmits it byte by byte on a UART TX line, most significant byte first. Each byte uses 8N1 framing. It sits between the coprocessor's `dout`/`dout_valid` outputs and the board's serial TX pin. It mirrors the receive-side packer that builds `din`.

---
 rtl/word_uart_tx.sv | 128 ++++++++++++
 tb/tb_word_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/word_uart_tx.sv
// Word-to-UART serializer: latches a WIDTH_DIN word and sends it MSB byte first as 8N1 frames.
// Optional feature macro WORD_UART_TX_NEWLINE_EN appends 0x0D, 0x0A frames after each word.
module word_uart_tx #(
  parameter int WIDTH_DIN    = 128,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic                 tx,
  output logic                 busy,
  output logic                 overrun
);

  localparam int NBYTES = WIDTH_DIN / 8;
`ifdef WORD_UART_TX_NEWLINE_EN
  localparam int NFRAMES = NBYTES + 2;
`else
  localparam int NFRAMES = NBYTES;
`endif
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NFRAMES + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NFRAMES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q;
  logic [WIDTH_DIN-1:0]   shreg_q;
  logic [IW-1:0]          idx_q;
  logic [2:0]             bit_q;
  logic [BW-1:0]          baud_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [7:0]             cur_byte_d;

  // The byte on the wire is always the top byte of the shift register,
  // unless the trailing newline frames are being sent.
  always_comb begin
    cur_byte_d = shreg_q[WIDTH_DIN-1 -: 8];
`ifdef WORD_UART_TX_NEWLINE_EN
    if (idx_q == IW'(NBYTES)) begin
      cur_byte_d = 8'h0D;
    end else if (idx_q == IW'(NBYTES + 1)) begin
      cur_byte_d = 8'h0A;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (din_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            shreg_q <= din;
            idx_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte_d[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte_d[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shreg_q <= shreg_q << 8;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              idx_q   <= idx_q + IW'(1);
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: expected line waveform and bytes are derived from 8N1 framing arithmetic.
// Build with WORD_UART_TX_NEWLINE_EN defined to check the newline variant.
module tb_word_uart_tx;
  localparam int W = 128;
  localparam int C = 4;
`ifdef WORD_UART_TX_NEWLINE_EN
  localparam int NF = W / 8 + 2;
`else
  localparam int NF = W / 8;
`endif
  localparam int T    = NF * 10 * C;
  localparam int MAXC = 2 * T + 64;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         tx, busy, overrun;

  always #5 clk = ~clk;

  word_uart_tx #(.WIDTH_DIN(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic       tx_log[$];
  logic       busy_log[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       exp_tx[MAXC];
  logic       exp_busy[MAXC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      exp_tx[i]   = 1'b1;
      exp_busy[i] = 1'b0;
    end
    exp_q.delete();
    rx_q.delete();
    tx_log.delete();
    busy_log.delete();
  endtask

  task automatic add_word(input int start, input logic [W-1:0] w);
    logic [7:0] b;
    int         pos;
    for (int f = 0; f < NF; f++) begin
      if (f < W / 8) b = 8'(w >> (W - 8 - 8 * f));
      else           b = (f == W / 8) ? 8'h0D : 8'h0A;
      exp_q.push_back(b);
      for (int s = 0; s < 10; s++) begin
        for (int c = 0; c < C; c++) begin
          pos = start + (f * 10 + s) * C + c;
          exp_tx[pos]   = (s == 0) ? 1'b0 : ((s == 9) ? 1'b1 : b[s-1]);
          exp_busy[pos] = 1'b1;
        end
      end
    end
  endtask

  // driver
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input logic [W-1:0] w, input int inj_a, input int inj_b,
                         input logic [W-1:0] inj_w, input bit scramble, input int ncap);
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < ncap; i++) begin
      @(negedge clk);
      tx_log.push_back(tx);
      busy_log.push_back(busy);
      din_valid = (i == inj_a) || (i == inj_b);
      if (din_valid)     din = inj_w;
      else if (scramble) din = {$urandom, $urandom, $urandom, $urandom};
    end
    din_valid = 1'b0;
  endtask

  // scoreboard: waveform compare plus a UART receiver sampling bit centres
  task automatic check_capture(input string tag, input int n_words);
    int tx_bad = 0, busy_bad = 0, busy_ones = 0, ferr = 0, j = 0;
    logic [7:0] b;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] !== exp_tx[i])     tx_bad++;
      if (busy_log[i] !== exp_busy[i]) busy_bad++;
      if (busy_log[i] === 1'b1)        busy_ones++;
    end
    while (j + 9 * C + C / 2 < tx_log.size()) begin
      if (tx_log[j] === 1'b0) begin
        if (tx_log[j + C / 2] !== 1'b0)         ferr++;
        if (tx_log[j + 9 * C + C / 2] !== 1'b1) ferr++;
        for (int s = 0; s < 8; s++) b[s] = tx_log[j + (s + 1) * C + C / 2];
        rx_q.push_back(b);
        j = j + 9 * C + C / 2 + 1;
      end else begin
        j++;
      end
    end
    chk($sformatf("%s tx_wave_errors", tag), tx_bad, 0);
    chk($sformatf("%s busy_wave_errors", tag), busy_bad, 0);
    chk($sformatf("%s busy_cycles", tag), busy_ones, n_words * T);
    chk($sformatf("%s framing_errors", tag), ferr, 0);
    chk($sformatf("%s rx_byte_count", tag), rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < rx_q.size()) chk($sformatf("%s rx_byte[%0d]", tag, k), rx_q[k], exp_q[k]);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    int           inj;

    // reset values
    #203;
    chk("reset tx", tx, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic word
    clear_model();
    w = -128'd50;
    add_word(0, w);
    capture(w, -1, -1, '0, 1'b0, T + 4);
    check_capture("basic", 1);
    chk("basic overrun", overrun, 1'b0);

    // 2: overrun mid-transfer
    clear_model();
    add_word(0, 128'd50);
    capture(128'd50, 100, -1, 128'd101, 1'b0, T + 4);
    check_capture("overrun", 1);
    chk("overrun set", overrun, 1'b1);
    repeat (20) @(negedge clk);
    chk("overrun sticky", overrun, 1'b1);

    // 3: strobe on the busy-fall edge is an overrun, the next edge is accepted
    do_reset();
    clear_model();
    add_word(0, 128'h5);
    add_word(T + 1, 128'd101);
    capture(128'h5, T - 1, T, 128'd101, 1'b0, 2 * T + 4);
    check_capture("b2b", 2);
    chk("b2b overrun", overrun, 1'b1);

    // 4: asynchronous reset during the data bits of byte 3
    @(negedge clk);
    din       = 128'd50;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (130) @(negedge clk);
    chk("midframe tx before reset", tx, 1'b0);
    chk("midframe busy before reset", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midframe reset tx", tx, 1'b1);
    chk("midframe reset busy", busy, 1'b0);
    chk("midframe reset overrun", overrun, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
    add_word(0, 128'd50);
    capture(128'd50, -1, -1, '0, 1'b0, T + 4);
    check_capture("after_reset", 1);
    chk("after_reset overrun", overrun, 1'b0);

    // 5: din changes every cycle after acceptance
    clear_model();
    w = 128'h0123456789ABCDEF0011223344556677;
    add_word(0, w);
    capture(w, -1, -1, '0, 1'b1, T + 4);
    check_capture("stability", 1);
    chk("stability overrun", overrun, 1'b0);

    // random words with scrambled din; first one also gets a random overrun strobe
    for (int r = 0; r < 3; r++) begin
      clear_model();
      w   = {$urandom, $urandom, $urandom, $urandom};
      inj = (r == 0) ? int'($urandom_range(1, T - 2)) : -1;
      add_word(0, w);
      capture(w, inj, -1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, T + 4);
      check_capture($sformatf("random%0d", r), 1);
      chk($sformatf("random%0d overrun", r), overrun, 1'b1 && (r >= 0) && (inj >= 0 || r > 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
